spinner_arbiter: RTL
====================

// Module: spinner_arbiter
// PURPOSE
// - Sequences the emulated Arkanoid spinner: arbitrates between mouse-delta and joystick-hold
//   requesters and drains a signed position backlog into the 2-bit AB quadrature fed to the core.
// - Sits between hps_io (ps2_mouse, joystick) and arkanoid.spinner; replaces the ad-hoc top-level logic.
// PARAMETERS
// - POS_W       12       position accumulator width (signed)
// - STEP_DIV    3000     clk_12m cycles per quadrature step (4 kHz)
// - JOY_PERIOD  96000    clk_12m cycles between joystick reloads (8 ms, 125 Hz poll)
// - JOY_SLOW    4        joystick reload magnitude, normal
// - JOY_FAST    9        joystick reload magnitude, fast button held
// - MOUSE_HOLD  1200000  clk_12m cycles mouse keeps ownership after its last event (100 ms)
// PORTS
// - clk_12m      in   1      system clock; single clock domain
// - reset        in   1      synchronous, active-low reset
// - mouse_toggle in   1      ps2_mouse[24]; any change = new mouse packet
// - mouse_dx     in   9      signed X delta; valid in the cycle mouse_toggle changes
// - joy_right    in   1      joystick right held
// - joy_left     in   1      joystick left held
// - joy_fast     in   1      selects JOY_FAST over JOY_SLOW
// - spinner      out  2      AB quadrature to core
// - position     out  POS_W  signed remaining backlog (debug/verification)
// - owner        out  1      1 = mouse owns spinner, 0 = joystick/idle
// - step_strobe  out  1      one-cycle pulse per quadrature step emitted
// BEHAVIOUR
// - Reset (reset==0 at edge): spinner=2'b11, position=0, owner=0, step_strobe=0, both timers=0,
//   toggle_q<=mouse_toggle (no spurious event on release). Reset mid-step discards the backlog.
// - Mouse event: evt = mouse_toggle ^ toggle_q; toggle_q updated every cycle. On evt: if position==0
//   or sign(position)==sign(mouse_dx): position += dx, saturated to +/-(2^(POS_W-1)-1);
//   else position = dx (reversal discards backlog). owner<=1, hold counter<=MOUSE_HOLD. Visible next cycle.
// - Ownership: hold counter decrements when nonzero; reaching 0 sets owner<=0 in the same edge.
// - Joystick (owner==0 only): exactly one of left/right held -> joy counter counts; at JOY_PERIOD-1
//   position <= +/-(joy_fast?JOY_FAST:JOY_SLOW) (right=+), counter<=0. Neither/both held, or owner==1:
//   counter<=0.
// - Step timer: free-running 0..STEP_DIV-1. At terminal count with position!=0: spinner advances one
//   state, position moves 1 toward 0, step_strobe=1 next cycle. position==0: no step, no strobe.
// - Quadrature FSM: position>0: 11->01->00->10->11; position<0: 11->10->00->01->11.
//   spinner never skips a state; at most one step per STEP_DIV cycles.
// - Same-cycle ordering (evaluated in order, single edge): step on old position, then joystick reload
//   (overwrites result), then mouse event (applied to result, wins over joystick; owner<=1).
// - Arithmetic: dx sign-extended to POS_W; saturation on add only; step never crosses zero.
// BEHAVIOUR LATENCY
// - evt at cycle N -> position/owner updated at edge N+1; first step at next step-timer terminal count.
// STRUCTURE
// - Package spinner_pkg: POS_W default, typedef enum logic [1:0] quad_t {Q11,Q01,Q00,Q10},
//   function quad_next(quad_t s, logic dir_neg), function sat_add(pos, dx).
// - Sub-module quad_step: holds quad_t state, inputs step/dir_neg, output spinner; reset to Q11.
// - Top holds edge detect, timers, ownership, accumulator.
// TESTING (bench overrides STEP_DIV=4, JOY_PERIOD=16, MOUSE_HOLD=40)
// - Reset held 3 cycles -> spinner=11, position=0, owner=0, step_strobe=0; release with toggle=1 -> no event.
// - Toggle, dx=+5 -> position=5, owner=1; 5 strobes 4 cycles apart, spinner 01,00,10,11,01; position 0, no 6th strobe.
// - dx=+3 then dx=-2 before drain (position 2) -> position=-2; next steps follow negative sequence.
// - position=2040, dx=+20 -> 2047; position=-2040, dx=-100 -> -2047.
// - owner=0, joy_right+joy_fast held -> position=9 after 16 cycles; left+right -> no reload;
//   after mouse event joystick ignored until 40 cycles elapse, then owner=0 and reloads resume.
// - Mouse event coincident with step tick and joystick reload, position=3 -> position=2+dx; reset
//   asserted mid-drain -> spinner=11, position=0 next cycle.

Source files
------------

// File: rtl/spinner_pkg.sv
// Shared types and helpers for the emulated Arkanoid spinner.
// Quadrature encoding matches the AB pin levels driven to the core.
package spinner_pkg;

  localparam int POS_W_DEF = 12;

  typedef enum logic [1:0] {
    Q11 = 2'b11,
    Q01 = 2'b01,
    Q00 = 2'b00,
    Q10 = 2'b10
  } quad_t;

  function automatic quad_t quad_next(
    input quad_t s,
    input logic  dir_neg
  );
    quad_t n;
    n = s;
    unique case (s)
      Q11: n = dir_neg ? Q10 : Q01;
      Q01: n = dir_neg ? Q11 : Q00;
      Q00: n = dir_neg ? Q01 : Q10;
      Q10: n = dir_neg ? Q00 : Q11;
      default: n = Q11;
    endcase
    return n;
  endfunction

  // Symmetric clamp so the backlog magnitude never exceeds 2^(w-1)-1.
  function automatic int sat_add(
    input int pos,
    input int dx,
    input int w
  );
    int lim;
    int sum;
    lim = (1 << (w - 1)) - 1;
    sum = pos + dx;
    if (sum > lim) return lim;
    if (sum < -lim) return -lim;
    return sum;
  endfunction

endpackage

// File: rtl/spinner_arbiter_quad_step.sv
// Quadrature state machine: one AB transition per step request.
// Direction follows the sign of the backlog being drained.
module spinner_arbiter_quad_step
  import spinner_pkg::*;
(
  input  logic       clk_12m,
  input  logic       reset,
  input  logic       step,
  input  logic       dir_neg,
  output logic [1:0] spinner
);

  quad_t state;
  quad_t state_n;

  always_ff @(posedge clk_12m) begin
    if (!reset) begin
      state <= Q11;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n = state;
    if (step) begin
      state_n = quad_next(state, dir_neg);
    end
  end

  assign spinner = state;

endmodule

// File: rtl/spinner_arbiter.sv
// Spinner arbiter: mouse/joystick ownership and backlog accumulator
// drained one quadrature step per STEP_DIV cycles.
module spinner_arbiter
  import spinner_pkg::*;
#(
  parameter int POS_W      = POS_W_DEF,
  parameter int STEP_DIV   = 3000,
  parameter int JOY_PERIOD = 96000,
  parameter int JOY_SLOW   = 4,
  parameter int JOY_FAST   = 9,
  parameter int MOUSE_HOLD = 1200000
) (
  input  logic                    clk_12m,
  input  logic                    reset,
  input  logic                    mouse_toggle,
  input  logic signed [8:0]       mouse_dx,
  input  logic                    joy_right,
  input  logic                    joy_left,
  input  logic                    joy_fast,
  output logic [1:0]              spinner,
  output logic signed [POS_W-1:0] position,
  output logic                    owner,
  output logic                    step_strobe
);

  localparam int SW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam int JW = (JOY_PERIOD > 1) ? $clog2(JOY_PERIOD) : 1;
  localparam int HW = $clog2(MOUSE_HOLD + 1);

  localparam logic [SW-1:0] STEP_LAST = SW'(STEP_DIV - 1);
  localparam logic [JW-1:0] JOY_LAST  = JW'(JOY_PERIOD - 1);
  localparam logic [HW-1:0] HOLD_INIT = HW'(MOUSE_HOLD);

  localparam logic signed [POS_W-1:0] ONE  = POS_W'(1);
  localparam logic signed [POS_W-1:0] SLOW = POS_W'(JOY_SLOW);
  localparam logic signed [POS_W-1:0] FAST = POS_W'(JOY_FAST);

  logic                    toggle_q;
  logic [SW-1:0]           step_cnt;
  logic [JW-1:0]           joy_cnt;
  logic [HW-1:0]           hold_cnt;
  logic                    evt;
  logic                    tick;
  logic                    pos_neg;
  logic                    do_step;
  logic                    joy_one;
  logic                    reload;
  logic signed [POS_W-1:0] joy_mag;
  logic signed [POS_W-1:0] dx_ext;
  logic signed [POS_W-1:0] pos_step;
  logic signed [POS_W-1:0] pos_joy;
  logic signed [POS_W-1:0] pos_mouse;
  logic signed [POS_W-1:0] pos_next;

  always_comb begin
    evt     = mouse_toggle ^ toggle_q;
    tick    = (step_cnt == STEP_LAST);
    pos_neg = position[POS_W-1];
    do_step = tick && (position != '0);
    joy_one = !owner && (joy_right ^ joy_left);
    reload  = joy_one && (joy_cnt == JOY_LAST);
    joy_mag = joy_fast ? FAST : SLOW;
    dx_ext  = {{(POS_W - 9){mouse_dx[8]}}, mouse_dx};

    pos_step = position;
    if (do_step) begin
      pos_step = pos_neg ? position + ONE : position - ONE;
    end

    pos_joy = pos_step;
    if (reload) begin
      pos_joy = joy_right ? joy_mag : -joy_mag;
    end

    // A mouse packet supersedes a same-edge joystick reload and
    // lands on the post-step backlog; reversal drops the backlog.
    pos_mouse = dx_ext;
    if (pos_step == '0 || pos_step[POS_W-1] == mouse_dx[8]) begin
      pos_mouse = POS_W'(sat_add(int'(pos_step), int'(dx_ext), POS_W));
    end

    pos_next = evt ? pos_mouse : pos_joy;
  end

  always_ff @(posedge clk_12m) begin
    if (!reset) begin
      toggle_q    <= mouse_toggle;
      step_cnt    <= '0;
      joy_cnt     <= '0;
      hold_cnt    <= '0;
      owner       <= 1'b0;
      position    <= '0;
      step_strobe <= 1'b0;
    end else begin
      toggle_q    <= mouse_toggle;
      step_cnt    <= tick ? '0 : step_cnt + 1'b1;
      joy_cnt     <= (joy_one && !reload) ? joy_cnt + 1'b1 : '0;
      step_strobe <= do_step;
      position    <= pos_next;
      if (evt) begin
        owner    <= 1'b1;
        hold_cnt <= HOLD_INIT;
      end else if (hold_cnt != '0) begin
        hold_cnt <= hold_cnt - 1'b1;
        if (hold_cnt == HW'(1)) begin
          owner <= 1'b0;
        end
      end
    end
  end

  spinner_arbiter_quad_step u_quad (
    .clk_12m (clk_12m),
    .reset   (reset),
    .step    (do_step),
    .dir_neg (pos_neg),
    .spinner (spinner)
  );

endmodule
